uart_tx_fifo: RTL and testbench

- UART 8N1 transmitter fed by a small synchronous write FIFO; drives the serial line into the board's uart_rx input at 9600 baud.
- Producer logic or a bench model pushes bytes; the block serialises them LSB-first with exact bit timing.
- Frame timing matches the capture model used by our lab benches: 10417 clocks per bit at 100 MHz.

---
 rtl/uart_tx_fifo.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a small synchronous write FIFO.
// Bytes are sent LSB-first, each bit held for a rounded CLK_FREQ/BAUD clocks.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AW       = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          busy,
  output logic          uart_tx
);

  localparam int unsigned DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count_nxt;
  logic            push;
  logic            pop;
  logic [CW-1:0]   div_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            bit_end;
  logic            tx_c;
  logic            busy_c;

  // Push decision uses the registered full flag, so a same-cycle pop never frees room.
  assign push    = wr_en & ~full;
  assign bit_end = (div_cnt == DIV_LAST);

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + (AW + 1)'(1);
      2'b01:   count_nxt = count - (AW + 1)'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage has no reset: contents are dead once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count    <= count_nxt;
      full     <= (count_nxt == DEPTH_CNT);
      empty    <= (count_nxt == '0);
      overflow <= wr_en & full;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; pops happen only when leaving IDLE or at the end of STOP.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (bit_end && (bit_idx == 3'd7)) begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line level and busy for the current state; registered below.
  always_comb begin
    tx_c   = 1'b1;
    busy_c = (state != IDLE);
    unique case (state)
      START:   tx_c = 1'b0;
      DATA:    tx_c = shift[0];
      default: tx_c = 1'b1;
    endcase
  end

  // Bit timing and data shifting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      uart_tx <= 1'b1;
      busy    <= 1'b0;
    end else begin
      if ((state == IDLE) || bit_end) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + CW'(1);
      end

      if (state != DATA) begin
        bit_idx <= '0;
      end else if (bit_end) begin
        bit_idx <= bit_idx + 3'd1;
      end

      if (pop) begin
        shift <= mem[rd_ptr];
      end else if ((state == DATA) && bit_end) begin
        shift <= {1'b0, shift[7:1]};
      end

      uart_tx <= tx_c;
      busy    <= busy_c;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: cycle-accurate timeline model of frame
// schedule plus an independent mid-bit line decoder.
module tb_uart_tx_fifo;

  localparam int unsigned CLK_FREQ = 125;
  localparam int unsigned BAUD     = 10;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned AW       = 4;
  // 125/10 = 12.5 rounds to 13 clocks per bit
  localparam int DIV   = 13;
  localparam int FRAME = 10 * DIV;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic        overflow;
  logic        busy;
  logic        uart_tx;

  uart_tx_fifo #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH), .AW(AW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .busy(busy), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Timeline model: every accepted byte gets a push edge and a pop edge.
  int         q_push[$];
  int         q_pop[$];
  logic [7:0] q_dat[$];
  int         last_pop;
  bit         m_ovf;
  int         cyc;

  // Per-test observation logs.
  logic [7:0] exp_rx[$];
  logic [7:0] rx_q[$];
  bit         line_log[$];
  bit         busy_log[$];
  int         ovf_n, ovf_idx, max_cnt, frame_err;

  function automatic void model_reset();
    q_push.delete();
    q_pop.delete();
    q_dat.delete();
    last_pop = -1000000;
    m_ovf    = 1'b0;
  endfunction

  function automatic int n_push_le(input int t);
    int n = 0;
    foreach (q_push[i]) if (q_push[i] <= t) n++;
    return n;
  endfunction

  function automatic int n_pop_le(input int t);
    int n = 0;
    foreach (q_pop[i]) if (q_pop[i] <= t) n++;
    return n;
  endfunction

  function automatic void model_edge(input logic we, input logic [7:0] d, input int t);
    int occ;
    int pt;
    if (!reset_n) begin
      model_reset();
      return;
    end
    occ   = n_push_le(t - 1) - n_pop_le(t - 1);
    m_ovf = 1'b0;
    if (we) begin
      if (occ >= int'(DEPTH)) begin
        m_ovf = 1'b1;
      end else begin
        pt = (t + 1 > last_pop + FRAME) ? t + 1 : last_pop + FRAME;
        q_push.push_back(t);
        q_pop.push_back(pt);
        q_dat.push_back(d);
        last_pop = pt;
        exp_rx.push_back(d);
      end
    end
  endfunction

  // Expected {uart_tx, busy, overflow, full, empty, count} after edge t.
  function automatic logic [9:0] exp_vec(input int t);
    int   c;
    int   k;
    logic tx;
    logic b;
    c  = n_push_le(t) - n_pop_le(t);
    tx = 1'b1;
    b  = 1'b0;
    foreach (q_pop[i]) begin
      if (t >= q_pop[i] + 1 && t <= q_pop[i] + FRAME) begin
        k  = (t - q_pop[i] - 1) / DIV;
        b  = 1'b1;
        tx = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : q_dat[i][k-1];
      end
    end
    return {tx, b, m_ovf, c == int'(DEPTH), c == 0, 5'(c)};
  endfunction

  task automatic tick(input logic we, input logic [7:0] d);
    wr_en   = we;
    wr_data = d;
    @(posedge clk);
    cyc++;
    model_edge(we, d, cyc);
    @(negedge clk);
    check_eq("cycle", {22'd0, uart_tx, busy, overflow, full, empty, count},
             {22'd0, exp_vec(cyc)});
    line_log.push_back(uart_tx);
    busy_log.push_back(busy);
    if (overflow) begin
      ovf_n++;
      ovf_idx = line_log.size() - 1;
    end
    if (int'(count) > max_cnt) max_cnt = int'(count);
    wr_en = 1'b0;
  endtask

  task automatic start_test();
    line_log.delete();
    busy_log.delete();
    exp_rx.delete();
    ovf_n   = 0;
    ovf_idx = -1;
    max_cnt = 0;
  endtask

  task automatic drain();
    int n = 0;
    repeat (3) tick(1'b0, 8'h00);
    while ((busy || !empty || cyc < last_pop + FRAME) && n < 30 * FRAME) begin
      tick(1'b0, 8'h00);
      n++;
    end
    check_eq("drain_timeout", 32'(n < 30 * FRAME), 32'd1);
    repeat (DIV) tick(1'b0, 8'h00);
  endtask

  // Mid-bit decoder over the logged line, independent of the model.
  function automatic void decode();
    int i = 0;
    rx_q.delete();
    frame_err = 0;
    while (i < line_log.size()) begin
      if (line_log[i] == 1'b0) begin
        logic [7:0] b;
        if (i + DIV / 2 + 9 * DIV >= line_log.size()) begin
          frame_err++;
          break;
        end
        if (line_log[i + DIV / 2] != 1'b0) frame_err++;
        for (int k = 0; k < 8; k++) b[k] = line_log[i + DIV / 2 + (k + 1) * DIV];
        if (line_log[i + DIV / 2 + 9 * DIV] != 1'b1) frame_err++;
        rx_q.push_back(b);
        i = i + DIV / 2 + 9 * DIV + 1;
      end else begin
        i++;
      end
    end
  endfunction

  task automatic check_rx(input string tag);
    decode();
    check_eq({tag, "_framing"}, 32'(frame_err), 32'd0);
    check_eq({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_rx.size()));
    foreach (exp_rx[i]) begin
      if (i < rx_q.size()) check_eq({tag, "_byte"}, {24'd0, rx_q[i]}, {24'd0, exp_rx[i]});
    end
  endtask

  function automatic int ones(input bit q[$]);
    int n = 0;
    foreach (q[i]) if (q[i]) n++;
    return n;
  endfunction

  initial begin
    logic [7:0] ok_str [4];
    int first_fall;
    int fb;
    int lb;
    int n;
    ok_str[0] = 8'h4F; ok_str[1] = 8'h4B; ok_str[2] = 8'h0D; ok_str[3] = 8'h0A;
    reset_n = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    cyc     = 0;
    model_reset();
    start_test();
    @(negedge clk);
    repeat (3) tick(1'b0, 8'h00);
    reset_n = 1'b1;

    // Idle after reset
    start_test();
    repeat (5 * DIV) tick(1'b0, 8'h00);
    check_eq("idle_line_ones", 32'(ones(line_log)), 32'(5 * DIV));
    check_eq("idle_busy", 32'(ones(busy_log)), 32'd0);

    // Single byte 0x41
    start_test();
    tick(1'b1, 8'h41);
    repeat (12 * DIV) tick(1'b0, 8'h00);
    first_fall = -1;
    foreach (line_log[i]) if (first_fall < 0 && line_log[i] == 1'b0) first_fall = i;
    check_eq("fall_latency", 32'(first_fall), 32'd2);
    check_eq("busy_len_41", 32'(ones(busy_log)), 32'(FRAME));
    check_rx("b41");

    // "OK\r\n" back to back
    start_test();
    for (int i = 0; i < 4; i++) tick(1'b1, ok_str[i]);
    drain();
    check_eq("ok_peak_count", 32'(max_cnt), 32'd3);
    fb = -1; lb = -1;
    foreach (busy_log[i]) if (busy_log[i]) begin
      if (fb < 0) fb = i;
      lb = i;
    end
    check_eq("ok_busy_span", 32'(lb - fb + 1), 32'(4 * FRAME));
    check_eq("ok_busy_total", 32'(ones(busy_log)), 32'(4 * FRAME));
    check_rx("ok");

    // 17 bytes: fills exactly, no overflow
    start_test();
    for (int i = 0; i < 17; i++) tick(1'b1, 8'(i));
    drain();
    check_eq("b17_ovf", 32'(ovf_n), 32'd0);
    check_eq("b17_peak", 32'(max_cnt), 32'(DEPTH));
    check_rx("b17");

    // 18 bytes: the 18th (0x11) is dropped
    start_test();
    for (int i = 0; i < 18; i++) tick(1'b1, 8'(i));
    drain();
    check_eq("b18_ovf_n", 32'(ovf_n), 32'd1);
    check_eq("b18_ovf_idx", 32'(ovf_idx), 32'd17);
    check_rx("b18");

    // Reset in DATA bit 4 of 0x55 with 3 bytes queued
    start_test();
    tick(1'b1, 8'h55);
    tick(1'b1, 8'hA1);
    tick(1'b1, 8'hA2);
    tick(1'b1, 8'hA3);
    while (line_log.size() < 2 + 5 * DIV + DIV / 2) tick(1'b0, 8'h00);
    check_eq("pre_rst_count", 32'(count), 32'd3);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_tx", 32'(uart_tx), 32'd1);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    repeat (3) tick(1'b0, 8'h00);
    reset_n = 1'b1;
    start_test();
    repeat (15 * DIV) tick(1'b0, 8'h00);
    check_eq("post_rst_busy", 32'(ones(busy_log)), 32'd0);
    check_eq("post_rst_line", 32'(ones(line_log)), 32'(15 * DIV));

    // 40 random bytes in bursts of 8, waiting for empty between bursts
    start_test();
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 8; i++) tick(1'b1, 8'($urandom_range(0, 255)));
      n = 0;
      while (!empty && n < 20 * FRAME) begin
        tick(1'b0, 8'h00);
        n++;
      end
      check_eq("burst_wait", 32'(empty), 32'd1);
    end
    drain();
    check_eq("burst_ovf", 32'(ovf_n), 32'd0);
    check_rx("burst");

    // Random push traffic, dense then sparse
    start_test();
    for (int i = 0; i < 80; i++) tick(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    for (int i = 0; i < 2000; i++)
      tick(1'($urandom_range(0, 149) == 0), 8'($urandom_range(0, 255)));
    drain();
    check_rx("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
